// File: rtl/nand_pkg.sv
// Shared constants, state encoding and address-byte helper for the NAND page-program controller.
package nand_pkg;

  localparam logic [7:0] CMD_PROG_SETUP   = 8'h80;
  localparam logic [7:0] CMD_PROG_CONFIRM = 8'h10;
  localparam int         PAGE_BYTES       = 512;
  localparam int         TWB_CYCLES       = 4;

  typedef enum logic [2:0] {
    IDLE,
    CMD80,
    ADDR,
    DATA,
    CMD10,
    TWB,
    WAIT_RB,
    DONE
  } state_e;

  // Address cycle idx -> byte on the bus: column 0, then the 9-bit row split over two cycles.
  function automatic logic [7:0] addr_byte(input logic [1:0] idx, input logic [8:0] page);
    case (idx)
      2'd1:    addr_byte = page[7:0];
      2'd2:    addr_byte = {7'b0, page[8]};
      default: addr_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/nand_wr_cycle.sv
// Two-clock flash write strobe: load clock drives WEN low, next clock raises it (flash latches there).
// A stall in the load phase holds WEN high and keeps the phase; cycle_done marks the rising-edge clock.
module nand_wr_cycle (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  input  logic stall_i,
  output logic load_o,
  output logic cycle_done_o,
  output logic wen_o
);

  logic phase_q, phase_d;
  logic wen_q, wen_d;

  assign load_o       = go_i & ~phase_q & ~stall_i;
  assign cycle_done_o = phase_q;
  assign wen_o        = wen_q;

  always_comb begin
    phase_d = phase_q;
    wen_d   = wen_q;
    if (phase_q) begin
      phase_d = 1'b0;
      wen_d   = 1'b1;
    end else if (load_o) begin
      phase_d = 1'b1;
      wen_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      wen_q   <= 1'b1;
    end else begin
      phase_q <= phase_d;
      wen_q   <= wen_d;
    end
  end

endmodule

// File: rtl/nand_page_program.sv
// Programs one 512-byte page: 80h, 3 address bytes, streamed data, 10h, tWB, wait on R/B.
// Two clocks per bus write; wr_ready only in the load phase, wr_valid=0 there stalls the byte.
module nand_page_program
  import nand_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] page_addr,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       busy,
  output logic       done,
  inout  wire  [7:0] F_IO_B,
  output logic       F_CLE_B,
  output logic       F_ALE_B,
  output logic       F_WEN_B,
  output logic       F_REN_B,
  input  logic       F_RB_B
);

  state_e     state_q;
  logic [8:0] addr_q;
  logic [8:0] cnt_q;
  logic [7:0] io_q;
  logic       io_oe_q;
  logic       cle_q;
  logic       ale_q;
  logic       busy_q;
  logic       done_q;

  logic bus_go;
  logic bus_stall;
  logic bus_load;
  logic bus_done;

  assign bus_go    = (state_q == CMD80) || (state_q == ADDR) ||
                     (state_q == DATA)  || (state_q == CMD10);
  assign bus_stall = (state_q == DATA) && !wr_valid;

  nand_wr_cycle u_wr_cycle (
    .clk          (clk),
    .rst          (rst),
    .go_i         (bus_go),
    .stall_i      (bus_stall),
    .load_o       (bus_load),
    .cycle_done_o (bus_done),
    .wen_o        (F_WEN_B)
  );

  assign wr_ready = (state_q == DATA) && !bus_done;
  assign busy     = busy_q;
  assign done     = done_q;
  assign F_CLE_B  = cle_q;
  assign F_ALE_B  = ale_q;
  assign F_REN_B  = 1'b1;
  assign F_IO_B   = io_oe_q ? io_q : 8'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      io_q    <= '0;
      io_oe_q <= 1'b0;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= page_addr;
            busy_q  <= 1'b1;
            state_q <= CMD80;
          end
        end
        CMD80: begin
          if (bus_load) begin
            io_q <= CMD_PROG_SETUP; io_oe_q <= 1'b1; cle_q <= 1'b1; ale_q <= 1'b0;
          end
          if (bus_done) state_q <= ADDR;
        end
        ADDR: begin
          if (bus_load) begin
            io_q <= addr_byte(cnt_q[1:0], addr_q); io_oe_q <= 1'b1; cle_q <= 1'b0; ale_q <= 1'b1;
          end
          if (bus_done) begin
            if (cnt_q == 9'd2) begin
              cnt_q   <= '0;
              state_q <= DATA;
            end else begin
              cnt_q <= cnt_q + 9'd1;
            end
          end
        end
        DATA: begin
          if (bus_load) begin
            io_q <= wr_data; io_oe_q <= 1'b1; cle_q <= 1'b0; ale_q <= 1'b0;
          end
          if (bus_done) begin
            if (cnt_q == 9'(PAGE_BYTES - 1)) begin
              cnt_q   <= '0;
              state_q <= CMD10;
            end else begin
              cnt_q <= cnt_q + 9'd1;
            end
          end
        end
        CMD10: begin
          if (bus_load) begin
            io_q <= CMD_PROG_CONFIRM; io_oe_q <= 1'b1; cle_q <= 1'b1; ale_q <= 1'b0;
          end
          if (bus_done) state_q <= TWB;
        end
        TWB: begin
          // First tWB clock is also the 10h hold after WEN rises; the bus is released at its end.
          io_oe_q <= 1'b0;
          cle_q   <= 1'b0;
          ale_q   <= 1'b0;
          if (cnt_q == 9'(TWB_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= WAIT_RB;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        WAIT_RB: begin
          if (F_RB_B) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_page_program.sv
// Directed bench: logs every WEN rising edge with CLE/ALE/IO and checks pages, stalls, R/B wait and reset abort.
module tb_nand_page_program;

  logic       clk;
  logic       rst;
  logic       start;
  logic [8:0] page_addr;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       busy;
  logic       done;
  wire  [7:0] f_io;
  logic       F_CLE_B, F_ALE_B, F_WEN_B, F_REN_B;
  logic       F_RB_B;

  nand_page_program dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .page_addr (page_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .F_IO_B    (f_io),
    .F_CLE_B   (F_CLE_B),
    .F_ALE_B   (F_ALE_B),
    .F_WEN_B   (F_WEN_B),
    .F_REN_B   (F_REN_B),
    .F_RB_B    (F_RB_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] log_q[$];
  int         log_t[$];
  logic       wen_prev = 1'b1;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (wen_prev == 1'b0 && F_WEN_B == 1'b1) begin
      log_q.push_back({F_CLE_B, F_ALE_B, f_io});
      log_t.push_back(cyc);
    end
    wen_prev = F_WEN_B;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_wait", n, 0);
    @(negedge clk);
  endtask

  task automatic stall7();
    int n, lows, nrdy;
    n = 0; lows = 0; nrdy = 0;
    wr_valid = 1'b0;
    while (wr_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 7; k++) begin
      if (F_WEN_B !== 1'b1) lows++;
      if (wr_ready !== 1'b1) nrdy++;
      @(negedge clk);
    end
    chk("stall_wen_low", lows, 0);
    chk("stall_ready_drop", nrdy, 0);
  endtask

  task automatic run_page(input logic [8:0] pa, input int nbytes, input bit do_stall);
    page_addr = pa;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    page_addr = 9'h000;
    for (int i = 0; i < nbytes; i++) begin
      if (do_stall && i == 100) stall7();
      send_byte(i[7:0]);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_log(input int want);
    int n;
    n = 0;
    while (log_q.size() < want && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("log_size", log_q.size(), want);
  endtask

  task automatic check_page(input int base, input logic [7:0] a1, input logic [7:0] a2, input int span);
    logic [7:0] e;
    if (log_q.size() >= base + 517) begin
      chk("cmd80", log_q[base],     {2'b10, 8'h80});
      chk("addr0", log_q[base + 1], {2'b01, 8'h00});
      chk("addr1", log_q[base + 2], {2'b01, a1});
      chk("addr2", log_q[base + 3], {2'b01, a2});
      for (int i = 0; i < 512; i++) begin
        e = i[7:0];
        chk("data", log_q[base + 4 + i], {2'b00, e});
      end
      chk("cmd10", log_q[base + 516], {2'b10, 8'h10});
      chk("data_span", log_t[base + 515] - log_t[base + 4], span);
    end
  endtask

  initial begin
    int base, d0, n, busy_lo, done_hi;
    rst = 1'b0; start = 1'b0; page_addr = '0; wr_data = '0; wr_valid = 1'b0; F_RB_B = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_cle", F_CLE_B, 0);
    chk("rst_ale", F_ALE_B, 0);
    chk("rst_wen", F_WEN_B, 1);
    chk("rst_ren", F_REN_B, 1);
    chk("rst_oe", dut.io_oe_q, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Page 1A5h with a 7-clock stall at byte 100 and a slow R/B.
    base = log_q.size();
    d0   = done_cnt;
    run_page(9'h1A5, 512, 1'b1);
    chk("busy_during", busy, 1);
    wait_log(base + 517);
    check_page(base, 8'hA5, 8'h01, 1029);
    @(negedge clk);
    chk("twb_released", dut.io_oe_q, 0);
    chk("twb_cle", F_CLE_B, 0);
    busy_lo = 0; done_hi = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i == 10 || i == 30);
      @(negedge clk);
      if (busy !== 1'b1) busy_lo++;
      if (done !== 1'b0) done_hi++;
    end
    start = 1'b0;
    chk("rb_wait_busy", busy_lo, 0);
    chk("rb_wait_done", done_hi, 0);
    F_RB_B = 1'b1;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("no_restart", log_q.size(), base + 517);
    chk("done_count", done_cnt - d0, 1);

    // Reset asserted right after data byte 299 is handed over.
    d0 = done_cnt;
    run_page(9'h0AB, 300, 1'b0);
    chk("pre_abort_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", wr_ready, 0);
    chk("abort_wen", F_WEN_B, 1);
    chk("abort_cle", F_CLE_B, 0);
    chk("abort_ale", F_ALE_B, 0);
    chk("abort_oe", dut.io_oe_q, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    // Fresh page 1FFh with full streaming and R/B already ready.
    base = log_q.size();
    d0   = done_cnt;
    run_page(9'h1FF, 512, 1'b0);
    wait_log(base + 517);
    check_page(base, 8'hFF, 8'h01, 1022);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("page2_done", done, 1);
    @(negedge clk);
    chk("page2_busy", busy, 0);
    chk("page2_done_count", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand_page_program.md
NAND_PAGE_PROGRAM -- requirements
Module: nand_page_program

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; the block is in reset while rst=0.
REQ-003 start  input  1  one-cycle request to program one page; honoured only in IDLE.
REQ-004 page_addr  input  9  target page index (0..511, 512-byte pages); captured on an accepted start.
REQ-005 wr_data  input  8  page byte from the upstream read stage.
REQ-006 wr_valid  input  1  wr_data is valid.
REQ-007 wr_ready  output  1  byte accepted on the cycle where wr_valid=1 and wr_ready=1.
REQ-008 busy  output  1  high from the accepted start until done.
REQ-009 done  output  1  one-cycle pulse when the page program completes.
REQ-010 F_IO_B  inout  8  flash B I/O bus; driven only in CMD, ADDR and DATA bus cycles, otherwise high-Z.
REQ-011 F_CLE_B, F_ALE_B, F_WEN_B, F_REN_B  output  1 each  flash B command-latch, address-latch, write-enable (active-low) and read-enable (active-low) strobes.
REQ-012 F_RB_B  input  1  flash B ready (1) / busy (0).

Function
REQ-013 States: IDLE, CMD80, ADDR, DATA, CMD10, TWB, WAIT_RB, DONE.
REQ-014 Bus write cycle = 2 clocks: phase 0 drives F_IO_B, CLE/ALE and F_WEN_B=0; phase 1 keeps F_IO_B, CLE/ALE and sets F_WEN_B=1; flash B latches on the WEN rising edge.
REQ-015 IDLE: start=1 -> capture page_addr, set busy=1, go to CMD80 on the next cycle; start while busy=1 is ignored.
REQ-016 CMD80: one bus cycle, F_IO_B=8'h80, CLE=1, ALE=0 -> ADDR.
REQ-017 ADDR: three bus cycles, ALE=1, CLE=0; bytes are 8'h00, page_addr[7:0], {7'b0, page_addr[8]} -> DATA.
REQ-018 DATA: 512 bus cycles, CLE=0, ALE=0; wr_ready=1 only in phase 0 of a data cycle.
REQ-019 DATA stall: if wr_valid=0 in phase 0, F_WEN_B stays 1, phase does not advance, F_IO_B holds its last value.
REQ-020 DATA byte counter is 9-bit; after the byte at count 511 completes phase 1 -> CMD10; the counter never wraps within a page.
REQ-021 CMD10: one bus cycle, F_IO_B=8'h10, CLE=1 -> TWB.
REQ-022 TWB: wait exactly 4 cycles (tWB) with bus high-Z, ignoring F_RB_B -> WAIT_RB.
REQ-023 WAIT_RB: when F_RB_B=1 -> DONE; no timeout.
REQ-024 DONE: done=1 for one cycle, busy=0 on the following cycle -> IDLE; start in the DONE cycle is ignored.
REQ-025 F_REN_B is constantly 1 (this block never reads).
REQ-026 wr_ready=0 in every state other than DATA phase 0.

Reset
REQ-027 On rst=0, immediately: state=IDLE, busy=0, done=0, wr_ready=0, F_CLE_B=0, F_ALE_B=0, F_WEN_B=1, F_REN_B=1, F_IO_B high-Z, counters cleared.
REQ-028 Reset asserted mid-operation aborts the page with no done pulse; the next start restarts at CMD80.

Structure
REQ-029 Shared package nand_pkg holds: CMD_PROG_SETUP=8'h80, CMD_PROG_CONFIRM=8'h10, PAGE_BYTES=512, TWB_CYCLES=4, and the state enum.
REQ-030 One sub-module, nand_wr_cycle: two-phase WEN generator taking go/stall and returning cycle_done; used for all CMD, ADDR and DATA cycles.

Verification
REQ-031 start with page_addr=9'h1A5 -> bus sequence 80h (CLE), then 00h, A5h, 01h (ALE), 512 data bytes, 10h (CLE); done one cycle after F_RB_B rises.
REQ-032 Stream 0..255,0..255 with wr_valid held 1 -> 1024 DATA clocks, each byte on F_IO_B at its WEN rising edge, no extra WEN pulses.
REQ-033 wr_valid deasserted for 7 cycles at byte 100 -> F_WEN_B stays 1 for those 7 cycles; byte 100 is written once with the correct value.
REQ-034 F_RB_B held 0 for 50 cycles after CMD10 -> busy stays 1 and done stays 0 until F_RB_B=1; start pulses during this time are ignored.
REQ-035 rst=0 at data byte 300 -> all outputs at reset values asynchronously, F_IO_B high-Z, no done pulse; a new start then completes a full page.
REQ-036 page_addr=9'h1FF -> address bytes 00h, FFh, 01h.
